// File: rtl/count_frame_packetizer_if.sv
// Sample stream bundle: AXI-Stream handshake plus the upstream count/final-count sideband.
interface count_frame_packetizer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [15:0]           count;
    logic                  final_cnt;

    modport master (output tvalid, tdata, tlast, count, final_cnt, input tready);
    modport slave  (input tvalid, tdata, tlast, count, final_cnt, output tready);
endinterface

// File: rtl/count_frame_packetizer.sv
// Frames each upstream count cycle into an AXI-Stream packet (optional header + samples),
// with a 2-entry registered output buffer and a sticky count-continuity flag.
module count_frame_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter bit HDR_EN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      sync_reset_n,
    input  logic [15:0]               cnt_limit,
    count_frame_packetizer_if.slave   s_axis,
    count_frame_packetizer_if.master  m_axis,
    output logic [15:0]               seq_num,
    output logic                      cnt_err
);
    localparam logic [0:0] S_HDR   = 1'b0;
    localparam logic [0:0] S_DATA  = 1'b1;
    localparam logic [0:0] S_FRAME = HDR_EN ? S_HDR : S_DATA;

    logic [0:0]            state_q, state_d;
    logic [1:0]            vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dat_q [2];
    logic [DATA_WIDTH-1:0] dat_d [2];
    logic [1:0]            lst_q, lst_d;
    logic [15:0]           seq_q, seq_d, exp_q, exp_d;
    logic                  err_q, err_d;

    logic                  rd, accept, hdr_wr, wr, wr_last, wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    // Ready depends only on registered state/occupancy so no path from m_axis.tready.
    assign s_axis.tready = sync_reset_n & (state_q == S_DATA) & ~vld_q[1];

    assign rd      = vld_q[0] & m_axis.tready;
    assign accept  = s_axis.tvalid & s_axis.tready;
    assign hdr_wr  = HDR_EN && (state_q == S_HDR) && s_axis.tvalid && !vld_q[1];
    assign wr      = accept | hdr_wr;
    assign wr_data = hdr_wr ? DATA_WIDTH'({seq_q, cnt_limit}) : s_axis.tdata;
    assign wr_last = hdr_wr ? 1'b0 : s_axis.final_cnt;

    always_comb begin
        vld_d    = vld_q;
        dat_d[0] = dat_q[0];
        dat_d[1] = dat_q[1];
        lst_d    = lst_q;
        if (rd) begin
            vld_d    = {1'b0, vld_q[1]};
            dat_d[0] = dat_q[1];
            lst_d[0] = lst_q[1];
        end
        // After the read shift, the first free slot is slot 1 iff slot 0 is still occupied.
        wr_idx = vld_d[0];
        if (wr) begin
            vld_d[wr_idx] = 1'b1;
            dat_d[wr_idx] = wr_data;
            lst_d[wr_idx] = wr_last;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        exp_d   = exp_q;
        err_d   = err_q;
        if (hdr_wr)
            state_d = S_DATA;
        if (accept) begin
            if (s_axis.count != exp_q)
                err_d = 1'b1;
            exp_d = s_axis.count + 16'd1;
            if (s_axis.final_cnt) begin
                seq_d   = seq_q + 16'd1;
                exp_d   = 16'd0;
                state_d = S_FRAME;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q  <= S_FRAME;
            vld_q    <= 2'b00;
            dat_q[0] <= '0;
            dat_q[1] <= '0;
            lst_q    <= 2'b00;
            seq_q    <= 16'd0;
            exp_q    <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            dat_q[0] <= dat_d[0];
            dat_q[1] <= dat_d[1];
            lst_q    <= lst_d;
            seq_q    <= seq_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
        end
    end

    assign m_axis.tvalid    = vld_q[0];
    assign m_axis.tdata     = dat_q[0];
    assign m_axis.tlast     = lst_q[0];
    assign m_axis.count     = 16'd0;
    assign m_axis.final_cnt = 1'b0;
    assign seq_num          = seq_q;
    assign cnt_err          = err_q;
endmodule
